alu_share_arbiter: RTL

- Shares the single combinational 32-bit ALU between two requesters: the integer execute stage (port 0) and the branch/compare helper (port 1).
- Arbitrates requests round-robin, drives the ALU operands and opcode, and captures the ALU result in a one-entry output register.
- Returns each result to the requester that issued it, with its tag, over a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_share_arbiter_pkg.sv | 24 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 36 +++
 rtl/alu_share_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode encoding,
// default widths and requester port identifiers.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SRA = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  // Requester identifiers; also the encoding of the arbiter pointer/grant.
  localparam logic PORT_EXE = 1'b0;
  localparam logic PORT_BR  = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer selects the favoured port under
// contention and moves to the other port whenever a grant is accepted.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_grant_valid,
  output logic       o_grant
);

  logic r_ptr;

  // Grant the only requester, or the pointer's port when both request.
  always_comb begin
    o_grant_valid = |i_valid;
    o_grant       = PORT_EXE;
    if (i_valid == 2'b11) begin
      o_grant = r_ptr;
    end else if (i_valid[1]) begin
      o_grant = PORT_BR;
    end
  end

  // Pointer hands priority to the other port after each accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_EXE;
    end else if (i_accept) begin
      r_ptr <= ~o_grant;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch/compare helper (port 1). The result lands in a one-entry output
// stage that is returned to the issuing port with its tag.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  logic              w_grant_valid;
  logic              w_grant;
  logic              w_owner_ready;
  logic              w_can_accept;
  logic              w_accept;
  logic [TAG_W-1:0]  w_grant_tag;

  logic              r_stage_valid;
  logic              r_owner;
  logic [DATA_W-1:0] r_rsp_data;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  // The stage can take a new op when empty or when it drains this cycle.
  assign w_owner_ready = (r_owner == PORT_BR) ? rsp1_ready : rsp0_ready;
  assign w_can_accept  = !r_stage_valid || w_owner_ready;
  assign w_accept      = w_can_accept && w_grant_valid;

  rr_arb2 u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       ({req1_valid, req0_valid}),
    .i_accept      (w_accept),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign req0_ready = w_accept && (w_grant == PORT_EXE);
  assign req1_ready = w_accept && (w_grant == PORT_BR);

  // Route the granted port's fields to the ALU; port 0 when idle.
  always_comb begin
    alu_op        = req0_op;
    alu_operand_a = req0_a;
    alu_operand_b = req0_b;
    w_grant_tag   = req0_tag;
    if (w_grant_valid && (w_grant == PORT_BR)) begin
      alu_op        = req1_op;
      alu_operand_a = req1_a;
      alu_operand_b = req1_b;
      w_grant_tag   = req1_tag;
    end
  end

  // Output stage: refill on accept, otherwise empty after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_valid <= 1'b0;
      r_owner       <= PORT_EXE;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
    end else if (w_accept) begin
      r_stage_valid <= 1'b1;
      r_owner       <= w_grant;
      r_rsp_data    <= alu_result;
      r_rsp_tag     <= w_grant_tag;
    end else if (r_stage_valid && w_owner_ready) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Per-port accepted-request counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (req1_ready && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign rsp0_valid = r_stage_valid && (r_owner == PORT_EXE);
  assign rsp1_valid = r_stage_valid && (r_owner == PORT_BR);
  assign rsp_data   = r_rsp_data;
  assign rsp_tag    = r_rsp_tag;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

endmodule
